// File: rtl/deck_deal_ctrl.sv
// Deck owner for the blackjack game: builds the rank deck, Fisher-Yates shuffles
// it in place with a Galois LFSR, then deals one card per grant to player/dealer.
module deck_deal_ctrl #(
  parameter int                 DECK_SIZE    = 52,
  parameter int                 LFSR_W       = 16,
  parameter logic [LFSR_W-1:0]  SEED_DEFAULT = 16'hACE1,
  parameter int                 LOW_MARK     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadseed_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              shuffle_i,
  input  logic [1:0]        req_i,
  output logic [1:0]        gnt_o,
  output logic              card_valid_o,
  output logic [3:0]        card_o,
  output logic              card_dst_o,
  output logic              busy_o,
  output logic [5:0]        cards_left_o,
  output logic              deck_low_o,
  output logic              deck_empty_o,
  output logic [2:0]        dbg_state_o,
  input  logic [5:0]        dbg_addr_i,
  output logic [3:0]        dbg_rank_o
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SIDX  = 3'd2,
    ST_SSWAP = 3'd3,
    ST_DEAL  = 3'd4
  } state_t;

  localparam logic [LFSR_W-1:0] LFSR_MASK = LFSR_W'(16'hB400);
  localparam logic [5:0]        LAST_SLOT = 6'(DECK_SIZE - 1);
  localparam logic [5:0]        FULL_DECK = 6'(DECK_SIZE);
  localparam logic [5:0]        LOW_LEVEL = 6'(LOW_MARK);

  state_t            state_q;
  logic [5:0]        idx_q;
  logic [5:0]        j_q;
  logic [3:0]        rank_q;
  logic [5:0]        ptr_q;
  logic [5:0]        left_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic              prio_q;
  logic [1:0]        gnt_q;
  logic              valid_q;
  logic [3:0]        card_q;
  logic              dst_q;
  logic [3:0]        deck_q [DECK_SIZE];

  logic [LFSR_W-1:0] lfsr_d;
  logic [13:0]       prod;
  logic [5:0]        j_d;
  logic [1:0]        gnt_d;

  // Handshake: req_i is a level held until gnt_o pulses; the card follows one
  // cycle later with card_valid_o, and a req_i still high then is a new request.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
    if (loadseed_i) lfsr_d = (seed_i == '0) ? SEED_DEFAULT : seed_i;
    // Scaled multiply keeps j in 0..i without a divider.
    prod = 14'(lfsr_q[7:0]) * 14'(idx_q + 6'd1);
    j_d  = 6'(prod >> 8);
    case (req_i)
      2'b01:   gnt_d = 2'b01;
      2'b10:   gnt_d = 2'b10;
      2'b11:   gnt_d = prio_q ? 2'b10 : 2'b01;
      default: gnt_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      j_q     <= '0;
      rank_q  <= 4'd1;
      ptr_q   <= '0;
      left_q  <= '0;
      lfsr_q  <= SEED_DEFAULT;
      prio_q  <= 1'b0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      card_q  <= '0;
      dst_q   <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          deck_q[idx_q] <= rank_q;
          rank_q        <= (rank_q == 4'd13) ? 4'd1 : rank_q + 4'd1;
          if (idx_q == LAST_SLOT) begin
            idx_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            idx_q <= idx_q + 6'd1;
          end
        end
        ST_IDLE: begin
          if (shuffle_i) begin
            idx_q   <= LAST_SLOT;
            left_q  <= '0;
            prio_q  <= 1'b0;
            state_q <= ST_SIDX;
          end else if (left_q != '0 && gnt_d != 2'b00) begin
            gnt_q   <= gnt_d;
            state_q <= ST_DEAL;
            if (req_i == 2'b11) prio_q <= ~prio_q;
          end
        end
        ST_SIDX: begin
          j_q     <= j_d;
          state_q <= ST_SSWAP;
        end
        ST_SSWAP: begin
          deck_q[idx_q] <= deck_q[j_q];
          deck_q[j_q]   <= deck_q[idx_q];
          if (idx_q == 6'd1) begin
            left_q  <= FULL_DECK;
            ptr_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            idx_q   <= idx_q - 6'd1;
            state_q <= ST_SIDX;
          end
        end
        ST_DEAL: begin
          valid_q <= 1'b1;
          card_q  <= deck_q[ptr_q];
          dst_q   <= gnt_q[1];
          ptr_q   <= ptr_q + 6'd1;
          left_q  <= left_q - 6'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign gnt_o        = gnt_q;
  assign card_valid_o = valid_q;
  assign card_o       = card_q;
  assign card_dst_o   = dst_q;
  assign cards_left_o = left_q;
  assign busy_o       = (state_q == ST_INIT) || (state_q == ST_SIDX) || (state_q == ST_SSWAP);
  assign deck_low_o   = (left_q <= LOW_LEVEL);
  assign deck_empty_o = (left_q == '0);
  assign dbg_state_o  = state_q;
  assign dbg_rank_o   = deck_q[dbg_addr_i];

endmodule

// File: tb/tb_deck_deal_ctrl.sv
// Directed bench for deck_deal_ctrl: init, seeded shuffle, dealing, round-robin
// arbitration, empty stall, reshuffle and reset during a shuffle.
module tb_deck_deal_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        loadseed_i = 1'b0;
  logic [15:0] seed_i = '0;
  logic        shuffle_i = 1'b0;
  logic [1:0]  req_i = '0;
  logic [5:0]  dbg_addr_i = '0;
  logic [1:0]  gnt_o;
  logic        card_valid_o;
  logic [3:0]  card_o;
  logic        card_dst_o;
  logic        busy_o;
  logic [5:0]  cards_left_o;
  logic        deck_low_o;
  logic        deck_empty_o;
  logic [2:0]  dbg_state_o;
  logic [3:0]  dbg_rank_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cur_seq [52];
  logic [3:0] run_a [52];

  deck_deal_ctrl dut (
    .clk(clk), .reset(reset), .loadseed_i(loadseed_i), .seed_i(seed_i),
    .shuffle_i(shuffle_i), .req_i(req_i), .gnt_o(gnt_o), .card_valid_o(card_valid_o),
    .card_o(card_o), .card_dst_o(card_dst_o), .busy_o(busy_o), .cards_left_o(cards_left_o),
    .deck_low_o(deck_low_o), .deck_empty_o(deck_empty_o), .dbg_state_o(dbg_state_o),
    .dbg_addr_i(dbg_addr_i), .dbg_rank_o(dbg_rank_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Fisher-Yates reference on a freshly initialised deck; l0 is the LFSR value seen by the first step.
  task automatic build_model(input logic [15:0] l0);
    logic [3:0]  d [52];
    logic [15:0] l;
    logic [3:0]  t;
    int          j;
    for (int k = 0; k < 52; k++) d[k] = 4'((k % 13) + 1);
    l = l0;
    for (int i = 51; i >= 1; i--) begin
      j = (int'(l[7:0]) * (i + 1)) >> 8;
      t = d[i]; d[i] = d[j]; d[j] = t;
      l = lfsr_adv(lfsr_adv(l));
    end
    exp_q.delete();
    for (int k = 0; k < 52; k++) exp_q.push_back(d[k]);
  endtask

  task automatic wait_busy(output int cycles, output bit gnt_seen);
    cycles = 0;
    gnt_seen = 1'b0;
    while (busy_o === 1'b1 && cycles < 300) begin
      if (gnt_o !== 2'b00) gnt_seen = 1'b1;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic start_shuffle(input logic [15:0] seed, input bit load, input bit same_cycle);
    if (load && !same_cycle) begin
      seed_i = seed; loadseed_i = 1'b1;
      @(negedge clk);
      loadseed_i = 1'b0;
    end
    seed_i = seed;
    loadseed_i = load && same_cycle;
    shuffle_i = 1'b1;
    @(negedge clk);
    loadseed_i = 1'b0;
    shuffle_i = 1'b0;
  endtask

  task automatic check_shuffle_done();
    int cyc;
    bit gs;
    wait_busy(cyc, gs);
    total_cnt++;
    if (cyc !== 102) $display("FAIL shuf_busy_len: got %0d cycles, want 102", cyc);
    else pass_cnt++;
    total_cnt++;
    if (gs !== 1'b0) $display("FAIL shuf_no_gnt: gnt seen during shuffle");
    else pass_cnt++;
    total_cnt++;
    if (cards_left_o !== 6'd52) $display("FAIL shuf_left: got %0d, want 52", cards_left_o);
    else pass_cnt++;
  endtask

  task automatic reset_and_init();
    int cyc;
    bit gs;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_busy(cyc, gs);
    total_cnt++;
    if (cyc !== 52) $display("FAIL init_len: got %0d cycles, want 52", cyc);
    else pass_cnt++;
  endtask

  task automatic draw_one(input bit side, output logic [3:0] card);
    logic [1:0] want;
    int t;
    want = side ? 2'b10 : 2'b01;
    req_i = want;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (gnt_o === 2'b00 && t < 20);
    req_i = 2'b00;
    total_cnt++;
    if (gnt_o !== want) $display("FAIL draw_gnt: got %b, want %b", gnt_o, want);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (card_valid_o !== 1'b1 || card_dst_o !== side)
      $display("FAIL draw_valid: valid=%b dst=%b, want valid=1 dst=%b", card_valid_o, card_dst_o, side);
    else pass_cnt++;
    card = card_o;
  endtask

  task automatic draw_deck();
    logic [3:0] c;
    int exp_left;
    for (int n = 0; n < 52; n++) begin
      exp_left = 52 - n;
      total_cnt++;
      if (cards_left_o !== 6'(exp_left) || deck_low_o !== (exp_left <= 10))
        $display("FAIL left_low: left=%0d low=%b, want left=%0d low=%b",
                 cards_left_o, deck_low_o, exp_left, (exp_left <= 10));
      else pass_cnt++;
      draw_one(1'b0, c);
      cur_seq[n] = c;
      total_cnt++;
      if (c !== exp_q[n]) $display("FAIL card_seq[%0d]: got %0d, want %0d", n, c, exp_q[n]);
      else pass_cnt++;
    end
    total_cnt++;
    if (deck_empty_o !== 1'b1 || cards_left_o !== 6'd0)
      $display("FAIL empty_after_deal: empty=%b left=%0d, want 1/0", deck_empty_o, cards_left_o);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    int cyc;
    bit gs;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({gnt_o, card_valid_o, card_o, card_dst_o, cards_left_o, deck_empty_o, deck_low_o, busy_o} !==
        {2'b00, 1'b0, 4'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1})
      $display("FAIL reset_vals: gnt=%b v=%b card=%0d dst=%b left=%0d empty=%b low=%b busy=%b",
               gnt_o, card_valid_o, card_o, card_dst_o, cards_left_o, deck_empty_o, deck_low_o, busy_o);
    else pass_cnt++;
    req_i = 2'b01;
    reset = 1'b1;
    wait_busy(cyc, gs);
    total_cnt++;
    if (cyc !== 52) $display("FAIL init_len: got %0d cycles, want 52", cyc);
    else pass_cnt++;
    repeat (5) begin
      if (gnt_o !== 2'b00) gs = 1'b1;
      @(negedge clk);
    end
    total_cnt++;
    if (gs !== 1'b0) $display("FAIL unshuffled_gnt: grant issued before shuffle");
    else pass_cnt++;
    total_cnt++;
    if (cards_left_o !== 6'd0 || deck_empty_o !== 1'b1)
      $display("FAIL init_empty: left=%0d empty=%b, want 0/1", cards_left_o, deck_empty_o);
    else pass_cnt++;
    req_i = 2'b00;
  endtask

  task automatic test_shuffle_draw_all();
    int cnt [14];
    start_shuffle(16'h0000, 1'b1, 1'b0);
    check_shuffle_done();
    build_model(lfsr_adv(16'hACE1));
    draw_deck();
    for (int r = 0; r < 14; r++) cnt[r] = 0;
    for (int n = 0; n < 52; n++) cnt[int'(cur_seq[n])]++;
    for (int r = 1; r <= 13; r++) begin
      total_cnt++;
      if (cnt[r] !== 4) $display("FAIL rank_count[%0d]: got %0d, want 4", r, cnt[r]);
      else pass_cnt++;
    end
  endtask

  task automatic test_seed_repeat();
    int ndiff;
    reset_and_init();
    start_shuffle(16'h1234, 1'b1, 1'b1);
    check_shuffle_done();
    build_model(16'h1234);
    draw_deck();
    run_a = cur_seq;
    reset_and_init();
    start_shuffle(16'h1234, 1'b1, 1'b1);
    check_shuffle_done();
    draw_deck();
    ndiff = 0;
    for (int n = 0; n < 52; n++) if (cur_seq[n] !== run_a[n]) ndiff++;
    total_cnt++;
    if (ndiff !== 0) $display("FAIL seed_repeat: %0d positions differ, want 0", ndiff);
    else pass_cnt++;
    reset_and_init();
    start_shuffle(16'h4321, 1'b1, 1'b1);
    check_shuffle_done();
    build_model(16'h4321);
    draw_deck();
    ndiff = 0;
    for (int n = 0; n < 52; n++) if (cur_seq[n] !== run_a[n]) ndiff++;
    total_cnt++;
    if (ndiff == 0) $display("FAIL seed_differs: sequences identical, want differing");
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int t;
    logic [1:0] eg;
    start_shuffle(16'h0000, 1'b0, 1'b0);
    check_shuffle_done();
    req_i = 2'b11;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (gnt_o === 2'b00 && t < 20);
    for (int c = 0; c < 16; c++) begin
      eg = (c % 2 == 1) ? 2'b00 : ((c % 4 == 0) ? 2'b01 : 2'b10);
      total_cnt++;
      if (gnt_o !== eg || card_valid_o !== (c % 2 == 1) || (c % 2 == 1 && card_dst_o !== (c % 4 == 3)))
        $display("FAIL rr_cycle[%0d]: gnt=%b v=%b dst=%b, want gnt=%b v=%b dst=%b",
                 c, gnt_o, card_valid_o, card_dst_o, eg, (c % 2 == 1), (c % 4 == 3));
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_exhaust_reshuffle();
    int t;
    bit gs;
    t = 0;
    while (cards_left_o !== 6'd0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    gs = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (gnt_o !== 2'b00) gs = 1'b1;
    end
    total_cnt++;
    if (deck_empty_o !== 1'b1 || deck_low_o !== 1'b1 || gs !== 1'b0)
      $display("FAIL empty_stall: empty=%b low=%b gnt_seen=%b, want 1/1/0", deck_empty_o, deck_low_o, gs);
    else pass_cnt++;
    start_shuffle(16'h0000, 1'b0, 1'b0);
    check_shuffle_done();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (gnt_o === 2'b00 && t < 20);
    total_cnt++;
    if (gnt_o !== 2'b01) $display("FAIL reshuf_first_gnt: got %b, want 01", gnt_o);
    else pass_cnt++;
    req_i = 2'b00;
    @(negedge clk);
    total_cnt++;
    if (card_valid_o !== 1'b1 || card_dst_o !== 1'b0 || cards_left_o !== 6'd51)
      $display("FAIL reshuf_deal: v=%b dst=%b left=%0d, want 1/0/51", card_valid_o, card_dst_o, cards_left_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_shuffle();
    int cyc;
    bit gs;
    @(negedge clk);
    start_shuffle(16'h0000, 1'b0, 1'b0);
    repeat (42) @(negedge clk);
    total_cnt++;
    if (dbg_state_o !== 3'd2 || busy_o !== 1'b1)
      $display("FAIL mid_shuf_state: state=%0d busy=%b, want 2/1", dbg_state_o, busy_o);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({gnt_o, card_valid_o, card_o, card_dst_o, cards_left_o, deck_empty_o, deck_low_o, busy_o} !==
        {2'b00, 1'b0, 4'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1})
      $display("FAIL abort_reset_vals: gnt=%b v=%b card=%0d dst=%b left=%0d empty=%b low=%b busy=%b",
               gnt_o, card_valid_o, card_o, card_dst_o, cards_left_o, deck_empty_o, deck_low_o, busy_o);
    else pass_cnt++;
    reset = 1'b1;
    wait_busy(cyc, gs);
    total_cnt++;
    if (cyc !== 52) $display("FAIL reinit_len: got %0d cycles, want 52", cyc);
    else pass_cnt++;
    for (int k = 0; k < 52; k++) begin
      dbg_addr_i = 6'(k);
      #1;
      total_cnt++;
      if (dbg_rank_o !== 4'((k % 13) + 1))
        $display("FAIL reinit_slot[%0d]: got %0d, want %0d", k, dbg_rank_o, (k % 13) + 1);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_shuffle_draw_all();
    test_seed_repeat();
    test_back_to_back();
    test_exhaust_reshuffle();
    test_reset_mid_shuffle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
